// File: rtl/dcache_mem_requester_pkg.sv
// Shared codes for the data-side memory requester: memory opcodes, memory
// status values, access-size codes and the requester FSM state type.
package dcache_mem_requester_pkg;

    localparam logic [1:0] MEM_NOP   = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    localparam logic [1:0] MEM_RESTING       = 2'b00;
    localparam logic [1:0] MEM_DATA_FINISHED = 2'b01;
    localparam logic [1:0] MEM_INST_FINISHED = 2'b10;

    localparam logic [2:0] ONE_BYTE  = 3'b000;
    localparam logic [2:0] TWO_BYTE  = 3'b001;
    localparam logic [2:0] FOUR_BYTE = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_RESP,
        ST_GAP
    } state_e;

    function automatic logic valid_data_type(input logic [2:0] dt);
        return (dt == ONE_BYTE) || (dt == TWO_BYTE) || (dt == FOUR_BYTE);
    endfunction

endpackage

// File: rtl/dcache_mem_requester.sv
// Turns data-cache line refills and store write-throughs into main-memory
// request/status beats, with an inline line buffer and beat counter.
module dcache_mem_requester
    import dcache_mem_requester_pkg::*;
#(
    parameter int ADDR_WIDTH       = 17,
    parameter int LEN              = 32,
    parameter int BYTE_SIZE        = 8,
    parameter int LINE_WORDS       = 4,
    parameter int ENTRY_INDEX_SIZE = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_WIDTH-1:0]        req_addr,
    input  logic [2:0]                   req_data_type,
    input  logic [LEN-1:0]               req_wdata,
    output logic                         resp_valid,
    output logic                         resp_err,
    output logic [LINE_WORDS*LEN-1:0]    resp_line,
    output logic [1:0]                   mem_vis_signal,
    output logic [ADDR_WIDTH-1:0]        mem_vis_addr,
    output logic [ENTRY_INDEX_SIZE:0]    mem_length,
    output logic [LEN-1:0]               mem_written_data,
    output logic [2:0]                   mem_data_type,
    input  logic [LEN-1:0]               mem_data,
    input  logic [1:0]                   mem_status
);

    localparam int WORD_BYTES = LEN / BYTE_SIZE;
    localparam int OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);
    localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int MLEN_W     = ENTRY_INDEX_SIZE + 1;

    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;
    localparam logic [MLEN_W-1:0]     READ_LEN   = MLEN_W'(LINE_WORDS);
    localparam logic [MLEN_W-1:0]     WRITE_LEN  = MLEN_W'(1);

    state_e                      state_q, state_d;
    logic [BEAT_W-1:0]           beat_q, beat_d;
    logic                        is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0]       base_q, base_d;
    logic [LINE_WORDS*LEN-1:0]   line_q, line_d;
    logic                        resp_valid_q, resp_valid_d;
    logic                        resp_err_q, resp_err_d;
    logic [1:0]                  sig_q, sig_d;
    logic [ADDR_WIDTH-1:0]       maddr_q, maddr_d;
    logic [MLEN_W-1:0]           mlen_q, mlen_d;
    logic [LEN-1:0]              wdata_q, wdata_d;
    logic [2:0]                  dtype_q, dtype_d;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [BEAT_W-1:0] beat);
        return base + ADDR_WIDTH'(32'(beat) * WORD_BYTES);
    endfunction

    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        is_write_d   = is_write_q;
        base_d       = base_q;
        line_d       = line_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        sig_d        = sig_q;
        maddr_d      = maddr_q;
        mlen_d       = mlen_q;
        wdata_d      = wdata_q;
        dtype_d      = dtype_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    is_write_d = req_write;
                    wdata_d    = req_wdata;
                    dtype_d    = req_data_type;
                    beat_d     = '0;
                    if (req_write) begin
                        base_d = req_addr;
                        if (!valid_data_type(req_data_type)) begin
                            state_d      = ST_GAP;
                            resp_valid_d = 1'b1;
                            resp_err_d   = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                            sig_d   = MEM_WRITE;
                            maddr_d = req_addr;
                            mlen_d  = WRITE_LEN;
                        end
                    end else begin
                        base_d  = req_addr & ALIGN_MASK;
                        state_d = ST_REQ;
                        sig_d   = MEM_READ;
                        maddr_d = req_addr & ALIGN_MASK;
                        mlen_d  = READ_LEN;
                    end
                end
            end
            ST_REQ: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (mem_status != MEM_RESTING) begin
                    state_d = ST_GAP;
                    sig_d   = MEM_NOP;
                    mlen_d  = '0;
                    if (is_write_q) begin
                        resp_valid_d = 1'b1;
                    end else begin
                        line_d[32'(beat_q)*LEN +: LEN] = mem_data;
                        if (beat_q == LAST_BEAT) begin
                            resp_valid_d = 1'b1;
                        end else begin
                            beat_d = beat_q + 1'b1;
                        end
                    end
                end
            end
            ST_GAP: begin
                // The response pulse marks the last GAP; otherwise more read beats remain.
                if (resp_valid_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_REQ;
                    sig_d   = MEM_READ;
                    maddr_d = beat_addr(base_q, beat_q);
                    mlen_d  = READ_LEN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            beat_q       <= '0;
            is_write_q   <= 1'b0;
            base_q       <= '0;
            line_q       <= '0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            sig_q        <= MEM_NOP;
            maddr_q      <= '0;
            mlen_q       <= '0;
            wdata_q      <= '0;
            dtype_q      <= '0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            is_write_q   <= is_write_d;
            base_q       <= base_d;
            line_q       <= line_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            sig_q        <= sig_d;
            maddr_q      <= maddr_d;
            mlen_q       <= mlen_d;
            wdata_q      <= wdata_d;
            dtype_q      <= dtype_d;
        end
    end

    assign req_ready        = (state_q == ST_IDLE);
    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_line        = line_q;
    assign mem_vis_signal   = sig_q;
    assign mem_vis_addr     = maddr_q;
    assign mem_length       = mlen_q;
    assign mem_written_data = wdata_q;
    assign mem_data_type    = dtype_q;

endmodule

// File: tb/tb_dcache_mem_requester.sv
// Directed plus randomized bench for dcache_mem_requester against a byte-array
// memory model with programmable stall and stale-status behaviour.
module tb_dcache_mem_requester;
    import dcache_mem_requester_pkg::*;

    localparam int AW    = 17;
    localparam int LW    = 4;
    localparam int MSIZE = 1 << AW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic            req_write = 1'b0;
    logic [AW-1:0]   req_addr = '0;
    logic [2:0]      req_data_type = '0;
    logic [31:0]     req_wdata = '0;
    logic            resp_valid;
    logic            resp_err;
    logic [127:0]    resp_line;
    logic [1:0]      mem_vis_signal;
    logic [AW-1:0]   mem_vis_addr;
    logic [3:0]      mem_length;
    logic [31:0]     mem_written_data;
    logic [2:0]      mem_data_type;
    logic [31:0]     mem_data;
    logic [1:0]      mem_status;

    dcache_mem_requester #(
        .ADDR_WIDTH(AW), .LEN(32), .BYTE_SIZE(8), .LINE_WORDS(LW), .ENTRY_INDEX_SIZE(3)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data_type(req_data_type), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
        .mem_vis_signal(mem_vis_signal), .mem_vis_addr(mem_vis_addr),
        .mem_length(mem_length), .mem_written_data(mem_written_data),
        .mem_data_type(mem_data_type), .mem_data(mem_data), .mem_status(mem_status)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0] store   [MSIZE];
    logic [7:0] ref_mem [MSIZE];

    int          stall_left = 0;
    logic [AW-1:0] stall_addr = '0;
    int          stale_mode = 0;
    int          stale_left = 0;

    function automatic int nbytes(input logic [2:0] dt);
        case (dt)
            ONE_BYTE:  return 1;
            TWO_BYTE:  return 2;
            FOUR_BYTE: return 4;
            default:   return 0;
        endcase
    endfunction

    function automatic int wrap(input int a);
        return a & (MSIZE - 1);
    endfunction

    // Main-memory model: status and read data are registered one cycle after the request is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_status <= MEM_RESTING;
            mem_data   <= '0;
            stale_left = 0;
        end else if (mem_vis_signal != MEM_NOP) begin
            if (stall_left > 0 && mem_vis_addr == stall_addr) begin
                stall_left--;
                mem_status <= MEM_RESTING;
            end else begin
                if (mem_vis_signal == MEM_READ) begin
                    mem_data <= {store[wrap(int'(mem_vis_addr))],   store[wrap(int'(mem_vis_addr)+1)],
                                 store[wrap(int'(mem_vis_addr)+2)], store[wrap(int'(mem_vis_addr)+3)]};
                end else begin
                    for (int i = 0; i < nbytes(mem_data_type); i++)
                        store[wrap(int'(mem_vis_addr)+i)] = mem_written_data[31-8*i -: 8];
                end
                mem_status <= MEM_DATA_FINISHED;
                stale_left = stale_mode;
            end
        end else if (stale_left > 0) begin
            stale_left--;
            mem_status <= MEM_DATA_FINISHED;
        end else begin
            mem_status <= MEM_RESTING;
        end
    end

    // Bus monitor: records each beat, counts writes/responses, flags unstable held requests.
    logic [AW-1:0] beat_addrs[$];
    int            n_write = 0;
    int            n_resp = 0;
    int            hold_viol = 0;
    int            len_viol = 0;
    logic [1:0]    prev_sig = MEM_NOP;
    logic [AW-1:0] prev_addr = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sig = MEM_NOP;
        end else begin
            if (mem_vis_signal != MEM_NOP && prev_sig == MEM_NOP) begin
                beat_addrs.push_back(mem_vis_addr);
                if (mem_vis_signal == MEM_WRITE) n_write++;
            end
            if (mem_vis_signal != MEM_NOP && prev_sig != MEM_NOP &&
                (mem_vis_signal != prev_sig || mem_vis_addr != prev_addr))
                hold_viol++;
            if ((mem_vis_signal == MEM_READ  && mem_length != 4'd4) ||
                (mem_vis_signal == MEM_WRITE && mem_length != 4'd1) ||
                (mem_vis_signal == MEM_NOP   && mem_length != 4'd0))
                len_viol++;
            if (resp_valid) n_resp++;
            prev_sig  = mem_vis_signal;
            prev_addr = mem_vis_addr;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ref_line(input logic [AW-1:0] a);
        logic [127:0] l;
        int base;
        base = int'(a) & ~(LW*4 - 1);
        l = '0;
        for (int k = 0; k < LW; k++)
            for (int b = 0; b < 4; b++)
                l[k*32 + (3-b)*8 +: 8] = ref_mem[wrap(base + 4*k + b)];
        return l;
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [2:0] dt, input logic [31:0] wd);
        for (int i = 0; i < nbytes(dt); i++)
            ref_mem[wrap(int'(a) + i)] = wd[31-8*i -: 8];
    endtask

    task automatic run_req(input logic w, input logic [AW-1:0] a, input logic [2:0] dt,
                           input logic [31:0] wd, output int lat, output logic err,
                           output logic [127:0] line);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        beat_addrs.delete();
        req_valid = 1'b1; req_write = w; req_addr = a; req_data_type = dt; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = AW'($urandom);
        req_wdata = $urandom;
        req_write = 1'($urandom);
        lat = -1; err = 1'bx; line = 'x;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                lat = c; err = resp_err; line = resp_line;
                break;
            end
        end
    endtask

    task automatic check_read_beats(input string tag, input logic [AW-1:0] a);
        logic [AW-1:0] base;
        base = a & ~AW'(LW*4 - 1);
        check({tag, "_nbeats"}, 128'(beat_addrs.size()), 128'(LW));
        if (beat_addrs.size() == LW)
            for (int k = 0; k < LW; k++)
                check({tag, "_beat_addr"}, 128'(beat_addrs[k]), 128'(base + AW'(4*k)));
    endtask

    initial begin : watchdog
        #500us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        logic err;
        logic [127:0] line;
        int wr0, resp0;
        logic w;
        logic [AW-1:0] a;
        logic [2:0] dt;
        logic [31:0] wd;
        int stall_n;

        for (int i = 0; i < MSIZE; i++) begin
            store[i]   = 8'(i - 16);
            ref_mem[i] = 8'(i - 16);
        end

        // Reset values
        #12;
        check("rst_sig",   128'(mem_vis_signal),   128'(MEM_NOP));
        check("rst_len",   128'(mem_length),       '0);
        check("rst_addr",  128'(mem_vis_addr),     '0);
        check("rst_wdata", 128'(mem_written_data), '0);
        check("rst_dtype", 128'(mem_data_type),    '0);
        check("rst_resp",  128'({resp_valid, resp_err}), '0);
        check("rst_line",  resp_line,              '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", 128'(req_ready), 128'(1));

        // Line read from an unaligned address
        run_req(1'b0, 17'h00013, ONE_BYTE, 32'h0, lat, err, line);
        check("read_lat",   128'(lat), 128'(12));
        check("read_err",   128'(err), 128'(0));
        check("read_word0", 128'(line[31:0]),   128'(32'h00010203));
        check("read_word3", 128'(line[127:96]), 128'(32'h0C0D0E0F));
        check("read_line",  line, ref_line(17'h00013));
        check_read_beats("read", 17'h00013);
        @(negedge clk);
        check("read_ready_c13", 128'(req_ready), 128'(1));
        check("read_line_held", resp_line, ref_line(17'h00013));

        // Byte write
        wr0 = n_write;
        run_req(1'b1, 17'h00025, ONE_BYTE, 32'hAB000000, lat, err, line);
        ref_write(17'h00025, ONE_BYTE, 32'hAB000000);
        check("bwr_lat",    128'(lat), 128'(3));
        check("bwr_err",    128'(err), 128'(0));
        check("bwr_beats",  128'(n_write - wr0), 128'(1));
        check("bwr_addr",   128'(beat_addrs.size() > 0 ? beat_addrs[0] : AW'(0)), 128'(17'h00025));
        @(negedge clk);
        check("bwr_byte",   128'(store[17'h25]), 128'(8'hAB));
        check("bwr_lo_nb",  128'(store[17'h24]), 128'(8'h14));
        check("bwr_hi_nb",  128'(store[17'h26]), 128'(8'h16));
        check("bwr_line_kept", resp_line, ref_line(17'h00013));

        // Stall of 5 cycles on beat 2
        stall_addr = 17'h00018; stall_left = 5;
        run_req(1'b0, 17'h0001C, ONE_BYTE, 32'h0, lat, err, line);
        check("stall_lat",  128'(lat), 128'(17));
        check("stall_line", line, ref_line(17'h0001C));
        check("stall_hold", 128'(hold_viol), 128'(0));
        check_read_beats("stall", 17'h0001C);

        // Stale FINISHED kept one extra cycle after each beat
        stale_mode = 1;
        run_req(1'b0, 17'h00020, ONE_BYTE, 32'h0, lat, err, line);
        check("stale_lat",  128'(lat), 128'(12));
        check("stale_line", line, ref_line(17'h00020));
        check_read_beats("stale", 17'h00020);
        stale_mode = 0;

        // Unsupported data type
        wr0 = n_write;
        run_req(1'b1, 17'h00040, 3'b111, 32'hDEADBEEF, lat, err, line);
        check("bad_lat",    128'(lat), 128'(1));
        check("bad_err",    128'(err), 128'(1));
        @(negedge clk);
        check("bad_nowrite", 128'(n_write - wr0), 128'(0));
        check("bad_ready",  128'(req_ready), 128'(1));

        // Word write wrapping past the top of the address space
        run_req(1'b1, 17'h1FFFE, FOUR_BYTE, 32'hCAFEF00D, lat, err, line);
        ref_write(17'h1FFFE, FOUR_BYTE, 32'hCAFEF00D);
        check("wrap_wr_lat", 128'(lat), 128'(3));
        run_req(1'b0, 17'h00001, ONE_BYTE, 32'h0, lat, err, line);
        check("wrap_line_lo", line, ref_line(17'h00001));
        run_req(1'b0, 17'h1FFFF, ONE_BYTE, 32'h0, lat, err, line);
        check("wrap_line_hi", line, ref_line(17'h1FFFF));

        // Reset in the middle of a read
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 17'h00100;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        resp0 = n_resp;
        rst_n = 1'b0;
        #1;
        check("mid_rst_sig",  128'(mem_vis_signal), 128'(MEM_NOP));
        check("mid_rst_line", resp_line, '0);
        check("mid_rst_resp", 128'(resp_valid), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 128'(req_ready), 128'(1));
        repeat (20) @(negedge clk);
        check("mid_rst_noresp", 128'(n_resp - resp0), 128'(0));

        // Randomized mix against the reference byte array
        for (int it = 0; it < 40; it++) begin
            w  = 1'($urandom_range(0, 1));
            a  = AW'(17'h1FFC0 + $urandom_range(0, 127));
            dt = (w && $urandom_range(0, 9) == 0) ? 3'b011 :
                 ($urandom_range(0, 2) == 0 ? ONE_BYTE : ($urandom_range(0, 1) == 0 ? TWO_BYTE : FOUR_BYTE));
            wd = $urandom;
            stale_mode = int'($urandom_range(0, 1));
            stall_n = int'($urandom_range(0, 3));
            if (w) stall_addr = a;
            else   stall_addr = (a & ~AW'(15)) + AW'(4 * $urandom_range(0, 3));
            stall_left = stall_n;
            wr0 = n_write;
            run_req(w, a, dt, wd, lat, err, line);
            if (w && nbytes(dt) == 0) begin
                check("rnd_bad_err", 128'(err), 128'(1));
                check("rnd_bad_lat", 128'(lat), 128'(1));
                check("rnd_bad_nowrite", 128'(n_write - wr0), 128'(0));
                stall_left = 0;
            end else if (w) begin
                ref_write(a, dt, wd);
                check("rnd_wr_err", 128'(err), 128'(0));
                check("rnd_wr_lat", 128'(lat), 128'(3 + stall_n));
                check("rnd_wr_beats", 128'(n_write - wr0), 128'(1));
            end else begin
                check("rnd_rd_err", 128'(err), 128'(0));
                check("rnd_rd_lat", 128'(lat), 128'(3*LW + stall_n));
                check("rnd_rd_line", line, ref_line(a));
            end
        end
        stale_mode = 0;
        @(negedge clk);
        check("rnd_hold", 128'(hold_viol), 128'(0));
        check("rnd_len",  128'(len_viol),  128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
